// File: rtl/alexander_pd_param.sv
// alexander_pd_param: bang-bang (Alexander) phase detector with an internal
// sampling-phase counter and a signed vote integrator for the receive CDR.
// Ports: i_clk work clock, i_rst sync active-low reset, i_en tracking enable,
//   i_phase sliced bit; o_strobe/o_data/o_T/o_E per-chip decision and flags,
//   o_up/o_dn one-cycle phase adjust pulses, o_acc vote accumulator,
//   o_lock lock flag (built only when PD_LOCK_DET_EN is defined, else 0).
module alexander_pd_param #(
    parameter int OSR     = 25,
    parameter int D_POS   = OSR / 2,
    parameter int VOTE_W  = 4,
    parameter int VOTE_TH = 4,
    parameter int LOCK_N  = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_phase,
    output logic              o_strobe,
    output logic              o_data,
    output logic              o_T,
    output logic              o_E,
    output logic              o_up,
    output logic              o_dn,
    output logic [VOTE_W-1:0] o_acc,
    output logic              o_lock
);
    localparam int CW = $clog2(OSR);
    localparam int XW = VOTE_W + 2;
    localparam logic [CW-1:0] C_LAST = CW'(OSR - 1);
    localparam logic [CW-1:0] C_PREV = CW'(OSR - 2);
    localparam logic [CW-1:0] C_DPOS = CW'(D_POS);
    localparam logic signed [XW-1:0] AMAX = XW'((1 <<< (VOTE_W - 1)) - 1);
    localparam logic signed [XW-1:0] AMIN = -AMAX;
    localparam logic signed [XW-1:0] V_P1 = XW'(1);
    localparam logic signed [XW-1:0] V_M1 = XW'(-1);
    localparam logic signed [VOTE_W-1:0] TH_P = VOTE_W'(VOTE_TH);
    localparam logic signed [VOTE_W-1:0] TH_N = VOTE_W'(-VOTE_TH);

    typedef enum logic [1:0] {IDLE, ACQ, TRACK} state_t;

    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic esmp_q, esmp_d;
    logic dcur_q, dcur_d;
    logic pend_e_q, pend_e_d;
    logic stb_q, stb_d;
    logic trans_q, trans_d;
    logic early_q, early_d;
    logic up_q, up_d;
    logic dn_q, dn_d;
    logic signed [VOTE_W-1:0] acc_q, acc_d;

    logic run, cap_e, cap_d, t_now, e_now;
    logic signed [XW-1:0] vote, acc_x;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        esmp_d   = esmp_q;
        dcur_d   = dcur_q;
        pend_e_d = pend_e_q;
        stb_d    = 1'b0;
        trans_d  = 1'b0;
        early_d  = 1'b0;
        up_d     = 1'b0;
        dn_d     = 1'b0;
        acc_d    = acc_q;
        t_now    = 1'b0;
        e_now    = 1'b0;
        vote     = '0;
        acc_x    = '0;
        run      = (state_q != IDLE);
        // pend_e: a double step jumped over cnt==0, take the edge sample now
        cap_e    = run && ((cnt_q == '0) || pend_e_q);
        cap_d    = run && (cnt_q == C_DPOS);
        if (!i_en) begin
            state_d  = IDLE;
            cnt_d    = '0;
            esmp_d   = 1'b0;
            dcur_d   = 1'b0;
            pend_e_d = 1'b0;
            acc_d    = '0;
        end else begin
            unique case (state_q)
                IDLE:    state_d = ACQ;
                ACQ:     if (cap_d) state_d = TRACK;
                TRACK:   state_d = TRACK;
                default: state_d = IDLE;
            endcase
            if (run) cnt_d = (cnt_q == C_LAST) ? '0 : cnt_q + 1'b1;
            if (cap_e) begin
                esmp_d   = i_phase;
                pend_e_d = 1'b0;
            end
            if (cap_d) begin
                dcur_d = i_phase;
                // first sample after acquisition has no valid predecessor
                if (state_q == TRACK) begin
                    t_now   = dcur_q ^ i_phase;
                    e_now   = t_now & ~(esmp_q ^ dcur_q);
                    stb_d   = 1'b1;
                    trans_d = t_now;
                    early_d = e_now;
                    if (t_now) vote = e_now ? V_P1 : V_M1;
                    acc_x = {{2{acc_q[VOTE_W-1]}}, acc_q} + vote;
                    if (acc_x > AMAX)      acc_d = AMAX[VOTE_W-1:0];
                    else if (acc_x < AMIN) acc_d = AMIN[VOTE_W-1:0];
                    else                   acc_d = acc_x[VOTE_W-1:0];
                end
            end
            // adjust one cycle after the strobe, from the updated votes
            if (stb_q) begin
                if (acc_q >= TH_P) begin
                    dn_d  = 1'b1;
                    acc_d = '0;
                    cnt_d = cnt_q;
                end else if (acc_q <= TH_N) begin
                    up_d  = 1'b1;
                    acc_d = '0;
                    if (cnt_q == C_LAST) begin
                        cnt_d    = CW'(1);
                        pend_e_d = 1'b1;
                    end else if (cnt_q == C_PREV) begin
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(2);
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            esmp_q   <= 1'b0;
            dcur_q   <= 1'b0;
            pend_e_q <= 1'b0;
            stb_q    <= 1'b0;
            trans_q  <= 1'b0;
            early_q  <= 1'b0;
            up_q     <= 1'b0;
            dn_q     <= 1'b0;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            esmp_q   <= esmp_d;
            dcur_q   <= dcur_d;
            pend_e_q <= pend_e_d;
            stb_q    <= stb_d;
            trans_q  <= trans_d;
            early_q  <= early_d;
            up_q     <= up_d;
            dn_q     <= dn_d;
            acc_q    <= acc_d;
        end
    end

    assign o_strobe = stb_q;
    assign o_data   = dcur_q;
    assign o_T      = trans_q;
    assign o_E      = early_q;
    assign o_up     = up_q;
    assign o_dn     = dn_q;
    assign o_acc    = acc_q;

`ifdef PD_LOCK_DET_EN
    localparam int LW = $clog2(LOCK_N + 1);
    localparam logic [LW-1:0] L_MAX = LW'(LOCK_N);

    logic [LW-1:0] lcnt_q, lcnt_d;

    always_comb begin
        lcnt_d = lcnt_q;
        if (!i_en || up_q || dn_q) begin
            lcnt_d = '0;
        end else if (stb_q && trans_q && !(up_d || dn_d) && (lcnt_q != L_MAX)) begin
            lcnt_d = lcnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) lcnt_q <= '0;
        else        lcnt_q <= lcnt_d;
    end

    assign o_lock = (lcnt_q == L_MAX);
`else
    assign o_lock = 1'b0 & (LOCK_N > 0);
`endif
endmodule

// File: doc/alexander_pd_param.md
Name: alexander_pd_param

Overview:
- Parametrised bang-bang (Alexander) phase detector with an integrated sampling-phase counter and a vote integrator, for the receive CDR on the 50 MHz work clock.
- Oversamples the hard-sliced phase bit stream and takes one data sample and one edge sample per chip.
- Produces per-chip transition/early flags and nudges its own sampling phase when accumulated votes cross a threshold.
- Sits between the demodulator slicer and the chip/despreader logic. Replaces the fixed-ratio detector plus its external counter.

Parameters:
- OSR, 25, clock cycles per chip (≥4); 50 MHz / 2 Mchip/s.
- D_POS, OSR/2, counter value at which the data sample is taken (1..OSR-2).
- VOTE_W, 4, signed vote accumulator width.
- VOTE_TH, 4, accumulator magnitude that triggers a phase adjust (1..2^(VOTE_W-1)-1).
- LOCK_N, 32, adjust-free transition count for lock (used only with the feature macro).

Ports:
- i_clk, in, 1, work clock, 50 MHz, rising edge.
- i_rst, in, 1, reset; synchronous, active-low.
- i_en, in, 1, tracking enable; low forces IDLE.
- i_phase, in, 1, sliced phase bit.
- o_strobe, out, 1, one-cycle pulse; o_T/o_E valid.
- o_data, out, 1, current data sample (chip decision).
- o_T, out, 1, transition between previous and current data sample.
- o_E, out, 1, early flag; valid only when o_T=1.
- o_up, out, 1, one-cycle pulse: phase advanced one cycle.
- o_dn, out, 1, one-cycle pulse: phase retarded one cycle.
- o_acc, out, VOTE_W, signed vote accumulator (debug).
- o_lock, out, 1, lock indication.

Behaviour:
- Reset (i_rst=0 at rising edge): cnt=0, acc=0, state=IDLE. All outputs 0. Reset mid-chip discards all samples.
- Phase counter cnt (width $clog2(OSR)) counts 0..OSR-1 and wraps; it runs in ACQ and TRACK only.
- Edge sample e is latched when cnt==0.
- Data sample d_cur is latched when cnt==D_POS; on that same cycle the old d_cur moves to d_prev.
- Evaluation happens on the cycle with cnt==D_POS+1 in TRACK. o_strobe=1 for one cycle with:
  - o_data = d_cur
  - o_T = d_prev ^ d_cur
  - o_E = o_T & ~(e ^ d_prev). E=1 means the edge sample still equals old data, i.e. sampling is early.
- States:
  - IDLE: cnt held at 0. Goes to ACQ when i_en=1.
  - ACQ: runs until the first data sample is taken (cnt==D_POS), then goes to TRACK. No strobe in ACQ.
  - TRACK: normal operation.
  - From any state, i_en=0 goes to IDLE next cycle. acc and lock state clear; in-flight strobe and adjust pulses are suppressed.
- Votes, applied on the strobe cycle:
  - o_T=1 and o_E=1: acc+1.
  - o_T=1 and o_E=0: acc-1.
  - o_T=0: acc unchanged.
- Adjust is decided from the updated acc value:
  - acc ≥ +VOTE_TH: o_dn pulses on the next cycle, acc clears to 0, and cnt holds (no increment) on that cycle.
  - acc ≤ -VOTE_TH: o_up pulses on the next cycle, acc clears to 0, and cnt steps by 2 modulo OSR (OSR-1 → 1, OSR-2 → 0).
  - At most one adjust per chip. o_up and o_dn are never high together.
- Wrap and adjust rules:
  - A hold at cnt==OSR-1 delays the wrap by one cycle.
  - A double step never skips the edge or data capture: if the step would jump over cnt==0 or cnt==D_POS, the capture is taken on the landing cycle.
- Accumulator arithmetic is signed saturating at ±(2^(VOTE_W-1)-1); the threshold clear normally prevents saturation.
- o_acc is the registered accumulator value.

Optional Feature:
- Macro: PD_LOCK_DET_EN.
- Defined:
  - A lock counter (width $clog2(LOCK_N+1)) increments on each strobe with o_T=1 that is not followed by an adjust, saturating at LOCK_N.
  - Any o_up or o_dn clears the counter.
  - o_lock=1 while counter==LOCK_N. It clears on reset, on i_en=0, and on the cycle after any adjust.
- Undefined: lock logic absent and o_lock tied to 0.

Test Plan (OSR=25, D_POS=12, VOTE_TH=4):
- Reset, then i_en=1 with constant i_phase=0: first o_strobe at cycle 38 after i_en (ACQ 0..12, then strobe at the next cnt==13, i.e. 25+13). Then every 25 cycles with o_T=0, acc=0, and no o_up/o_dn.
- Alternating chips with edge exactly at cnt 3 (transition after edge sample): each strobe gives o_T=1, o_E=1. On the 4th strobe acc reaches 4, o_dn pulses next cycle, acc=0, and that chip lasts 26 cycles.
- Transitions at cnt 22 of the previous chip (before the edge sample): o_E=0, acc decrements. The 4th transition gives o_up, acc=0, and that chip lasts 24 cycles.
- Alternating early/late transitions: acc toggles between +1 and 0; no adjust ever occurs.
- i_rst=0 asserted at cnt=12 mid-TRACK: next cycle all outputs are 0 and cnt=0. Re-acquisition timing is identical to the first scenario.
- With PD_LOCK_DET_EN and LOCK_N=32: 32 balanced transitions give o_lock=1; forcing one o_dn drops o_lock the cycle after.
